// File: rtl/ifetch_resp_if.sv
// Fetch port between the control unit, the fetch responder and the byte-wide memory.
// The master side drives requests and memory responses; the slave side is the responder.
interface ifetch_resp_if #(
  parameter int AW     = 16,
  parameter int NBYTES = 4
);
  logic                  req_valid;
  logic [AW-1:0]         req_addr;
  logic                  flush;
  logic [8*NBYTES-1:0]   raw;
  logic                  raw_valid;
  logic                  busy;
  logic                  mem_req;
  logic [AW-1:0]         mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_data;

  modport master (
    output req_valid, req_addr, flush, mem_ack, mem_data,
    input  raw, raw_valid, busy, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_ack, mem_data,
    output raw, raw_valid, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: reads NBYTES consecutive bytes over a req/ack byte bus and
// returns them packed MSB-first, with a one-entry line buffer answering repeat fetches.
module ifetch_resp #(
  parameter int AW     = 16,
  parameter int NBYTES = 4
) (
  input logic          clk,
  input logic          rst,
  ifetch_resp_if.slave bus
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RW = 8 * NBYTES;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [RW-1:0] raw_r, raw_s;
  logic [RW-1:0] asm_r, asm_s, asm_ins_s;
  logic          raw_valid_r, raw_valid_s;
  logic          mem_req_r, mem_req_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [AW-1:0] base_r, base_s;
  logic [AW-1:0] buf_addr_r, buf_addr_s;
  logic          buf_valid_r, buf_valid_s;
  logic [IW-1:0] idx_r, idx_s;
  logic          hit_s, ack_s;

  assign hit_s = buf_valid_r && (bus.req_addr == buf_addr_r);
  assign ack_s = bus.mem_ack && mem_req_r;

  // Insert the returned byte at position idx; byte 0 lands in the top of the word
  always_comb begin
    asm_ins_s = asm_r;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_r == IW'(i)) begin
        asm_ins_s[8*(NBYTES-1-i) +: 8] = bus.mem_data;
      end else begin
        asm_ins_s[8*(NBYTES-1-i) +: 8] = asm_r[8*(NBYTES-1-i) +: 8];
      end
    end
  end

  // Next-state and next-output logic; flush wins over request and ack
  always_comb begin
    state_s     = state_r;
    raw_s       = raw_r;
    raw_valid_s = 1'b0;
    mem_req_s   = mem_req_r;
    mem_addr_s  = mem_addr_r;
    base_s      = base_r;
    buf_addr_s  = buf_addr_r;
    buf_valid_s = buf_valid_r;
    idx_s       = idx_r;
    asm_s       = asm_r;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          buf_valid_s = 1'b0;
        end else if (bus.req_valid) begin
          if (hit_s) begin
            raw_valid_s = 1'b1;
          end else begin
            state_s    = FETCH;
            base_s     = bus.req_addr;
            mem_req_s  = 1'b1;
            mem_addr_s = bus.req_addr;
            idx_s      = '0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.flush) begin
          state_s     = IDLE;
          mem_req_s   = 1'b0;
          buf_valid_s = 1'b0;
          idx_s       = '0;
        end else if (ack_s) begin
          asm_s = asm_ins_s;
          if (idx_r == LAST_IDX) begin
            raw_s       = asm_ins_s;
            raw_valid_s = 1'b1;
            buf_addr_s  = base_r;
            buf_valid_s = 1'b1;
            mem_req_s   = 1'b0;
            idx_s       = '0;
            state_s     = IDLE;
          end else begin
            idx_s      = idx_r + IW'(1);
            mem_addr_s = mem_addr_r + AW'(1);
          end
        end else begin
          state_s = FETCH;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      raw_r       <= '0;
      raw_valid_r <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      base_r      <= '0;
      buf_addr_r  <= '0;
      buf_valid_r <= 1'b0;
      idx_r       <= '0;
      asm_r       <= '0;
    end else begin
      state_r     <= state_s;
      raw_r       <= raw_s;
      raw_valid_r <= raw_valid_s;
      mem_req_r   <= mem_req_s;
      mem_addr_r  <= mem_addr_s;
      base_r      <= base_s;
      buf_addr_r  <= buf_addr_s;
      buf_valid_r <= buf_valid_s;
      idx_r       <= idx_s;
      asm_r       <= asm_s;
    end
  end

  assign bus.raw       = raw_r;
  assign bus.raw_valid = raw_valid_r;
  assign bus.busy      = (state_r == FETCH);
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_addr  = mem_addr_r;
endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: memory responder with configurable wait states, raw-word scoreboard.
module tb_ifetch_resp;
  localparam int AW = 16;
  localparam int NB = 4;

  logic clk;
  logic rst;

  ifetch_resp_if #(.AW(AW), .NBYTES(NB)) bus ();
  ifetch_resp #(.AW(AW), .NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0]  mem [0:65535];
  logic [31:0] exp_q [$];
  logic [15:0] reads_q [$];
  int wait_n;
  int mreq_cycles;
  int errors;
  int checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    logic [15:0] p;
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < NB; i++) begin
      p = a + 16'(i);
      w = {w[23:0], mem[p]};
    end
    return w;
  endfunction

  // Byte memory: acks after wait_n idle cycles of a held request
  initial begin : responder
    int cnt;
    logic [15:0] hold;
    cnt = 0;
    hold = 16'h0;
    bus.mem_ack = 1'b0;
    bus.mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        mreq_cycles++;
        if (cnt > 0) check_eq("addr_stable", 32'(bus.mem_addr), 32'(hold));
        hold = bus.mem_addr;
        if (cnt == wait_n) begin
          bus.mem_ack = 1'b1;
          bus.mem_data = mem[bus.mem_addr];
          reads_q.push_back(bus.mem_addr);
          cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_data = 8'hEE;
          cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.raw_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_raw_valid", 32'(bus.raw_valid), 32'h0);
        else check_eq("raw", bus.raw, exp_q.pop_front());
      end
    end
  end

  task automatic do_fetch(input string tag, input logic [15:0] a, input logic [31:0] w,
                          input int exp_lat, input int exp_reads);
    int lat;
    int r0;
    int m0;
    r0 = reads_q.size();
    m0 = mreq_cycles;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.raw_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_reads"}, 32'(reads_q.size() - r0), 32'(exp_reads));
    if (exp_reads == 0) check_eq({tag, "_mem_req_cycles"}, 32'(mreq_cycles - m0), 32'h0);
    for (int i = 0; i < exp_reads && r0 + i < reads_q.size(); i++) begin
      logic [15:0] ea;
      ea = a + 16'(i);
      check_eq({tag, "_addr"}, 32'(reads_q[r0 + i]), 32'(ea));
    end
    @(negedge clk);
  endtask

  initial begin : main
    int r0;
    errors = 0;
    checks = 0;
    wait_n = 0;
    mreq_cycles = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr = 16'h0;
    bus.flush = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 5);
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_raw", bus.raw, 32'h0);
    check_eq("rst_raw_valid", 32'(bus.raw_valid), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    rst = 1'b0;

    do_fetch("miss", 16'h0100, 32'h11223344, 5, 4);
    do_fetch("hit", 16'h0100, 32'h11223344, 1, 0);

    // Flush together with a request: not accepted, buffer dropped
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 16'h0100;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    check_eq("idle_flush_raw_valid", 32'(bus.raw_valid), 32'h0);
    check_eq("idle_flush_busy", 32'(bus.busy), 32'h0);

    wait_n = 2;
    do_fetch("wait", 16'h0100, 32'h11223344, 13, 4);
    wait_n = 0;
    do_fetch("wrap", 16'hFFFE, 32'hA1B2C3D4, 5, 4);
    do_fetch("wrap_hit", 16'hFFFE, 32'hA1B2C3D4, 1, 0);

    // Flush while the third byte is acked
    r0 = reads_q.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 16'h0200;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check_eq("flush_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("flush_busy", 32'(bus.busy), 32'h0);
    check_eq("flush_raw_valid", 32'(bus.raw_valid), 32'h0);
    check_eq("flush_raw_hold", bus.raw, 32'hA1B2C3D4);
    repeat (3) @(negedge clk);
    check_eq("flush_reads", 32'(reads_q.size() - r0), 32'd3);
    do_fetch("post_flush_old", 16'hFFFE, 32'hA1B2C3D4, 5, 4);
    do_fetch("post_flush_same", 16'h0200, exp_word(16'h0200), 5, 4);

    // Reset after two bytes of a fetch; the ack in the reset cycle must be ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr = 16'h0300;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_raw", bus.raw, 32'h0);
    check_eq("midrst_raw_valid", 32'(bus.raw_valid), 32'h0);
    check_eq("midrst_busy", 32'(bus.busy), 32'h0);
    check_eq("midrst_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("midrst_mem_addr", 32'(bus.mem_addr), 32'h0);
    repeat (2) @(negedge clk);
    do_fetch("post_rst", 16'h0200, exp_word(16'h0200), 5, 4);
    do_fetch("post_rst_hit", 16'h0200, exp_word(16'h0200), 1, 0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
